bp_clint_mhart: RTL and testbench

BP_CLINT_MHART -- requirements
Module: bp_clint_mhart

---
 rtl/bp_common_pkg.sv | 24 ++
 rtl/bp_clint_mtime.sv | 39 +++
 rtl/bp_clint_mhart.sv | 160 ++++++++++++++++
 tb/tb_bp_clint_mhart.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_common_pkg.sv
// rtl/bp_common_pkg.sv - shared device map, CLINT offsets and CLINT request/response struct macro
package bp_common_pkg;

    localparam logic [63:0] cfg_dev_base_addr_gp   = 64'h0020_0000;
    localparam logic [63:0] clint_dev_base_addr_gp = 64'h0030_0000;
    localparam logic [63:0] cache_dev_base_addr_gp = 64'h0040_0000;

    localparam logic [15:0] clint_msip_offset_gp     = 16'h0000;
    localparam logic [15:0] clint_mtimecmp_offset_gp = 16'h4000;
    localparam logic [15:0] clint_mtime_offset_gp    = 16'h8000;
    localparam int          clint_reg_width_gp       = 64;

endpackage

`define DECLARE_BP_CLINT_REQ_RESP_S(paddr_width_mp) \
    typedef struct packed { \
        logic                          w; \
        logic [paddr_width_mp-1:0]     addr; \
        logic [clint_reg_width_gp-1:0] data; \
    } bp_clint_req_s; \
    typedef struct packed { \
        logic [clint_reg_width_gp-1:0] data; \
        logic                          err; \
    } bp_clint_resp_s;

// File: rtl/bp_clint_mtime.sv
// rtl/bp_clint_mtime.sv - mtime counter advanced once every mtime_div_p clocks
module bp_clint_mtime
    import bp_common_pkg::*;
#(
    parameter int mtime_div_p = 1
) (
    input  logic                          i_clk,
    input  logic                          i_reset_n,
    input  logic                          i_w_v,
    input  logic [clint_reg_width_gp-1:0] i_w_data,
    output logic [clint_reg_width_gp-1:0] o_mtime
);

    localparam logic [15:0] div_last = 16'(mtime_div_p - 1);

    logic [15:0]                   r_prescale;
    logic [clint_reg_width_gp-1:0] r_mtime;
    logic                          w_tick;

    assign w_tick  = (r_prescale == div_last);
    assign o_mtime = r_mtime;

    // A software load wins over a coincident tick and restarts the prescale period
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_prescale <= '0;
            r_mtime    <= '0;
        end else if (i_w_v) begin
            r_prescale <= '0;
            r_mtime    <= i_w_data;
        end else if (w_tick) begin
            r_prescale <= '0;
            r_mtime    <= r_mtime + 1'b1;
        end else begin
            r_prescale <= r_prescale + 16'd1;
        end
    end

endmodule

// File: rtl/bp_clint_mhart.sv
// rtl/bp_clint_mhart.sv - multi-hart CLINT: msip, mtimecmp, shared mtime, single-slot response
// Macro BP_CLINT_MTIME_WRITE_EN: allow software writes to mtime (otherwise decode error).
module bp_clint_mhart
    import bp_common_pkg::*;
#(
    parameter int num_harts_p   = 1,
    parameter int paddr_width_p = 40,
    parameter int mtime_div_p   = 1
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     req_v_i,
    output logic                     req_ready_o,
    input  logic                     req_w_i,
    input  logic [paddr_width_p-1:0] req_addr_i,
    input  logic [63:0]              req_data_i,
    output logic                     resp_v_o,
    input  logic                     resp_yumi_i,
    output logic [63:0]              resp_data_o,
    output logic                     resp_err_o,
    output logic [num_harts_p-1:0]   soft_irq_o,
    output logic [num_harts_p-1:0]   timer_irq_o
);

    `DECLARE_BP_CLINT_REQ_RESP_S(paddr_width_p)

    localparam logic [paddr_width_p-17:0] dev_hi = clint_dev_base_addr_gp[paddr_width_p-1:16];

    bp_clint_req_s                 w_req;
    bp_clint_resp_s                w_resp;
    bp_clint_resp_s                r_resp;
    logic                          r_resp_v;
    logic [15:0]                   w_off;
    logic [10:0]                   w_hart;
    logic                          w_base_ok;
    logic                          w_align_ok;
    logic                          w_hart_ok;
    logic                          w_is_msip;
    logic                          w_is_cmp;
    logic                          w_is_mtime;
    logic                          w_mtime_ok;
    logic                          w_err;
    logic                          w_accept;
    logic                          w_wr_ok;
    logic                          w_mtime_we;
    logic                          w_msip_rd;
    logic [clint_reg_width_gp-1:0] w_cmp_rd;
    logic [clint_reg_width_gp-1:0] w_mtime;
    logic [num_harts_p-1:0]        w_msip_we;
    logic [num_harts_p-1:0]        w_cmp_we;
    logic [num_harts_p-1:0]        r_msip;
    logic [num_harts_p-1:0]        r_timer_irq;
    logic [clint_reg_width_gp-1:0] r_mtimecmp [num_harts_p];

    assign w_req = '{w: req_w_i, addr: req_addr_i, data: req_data_i};

    assign w_off      = w_req.addr[15:0];
    assign w_hart     = w_off[13:3];
    assign w_base_ok  = (w_req.addr[paddr_width_p-1:16] == dev_hi);
    assign w_align_ok = (w_off[2:0] == 3'b000);
    assign w_hart_ok  = ({5'd0, w_hart} < 16'(num_harts_p));
    assign w_is_msip  = (w_off[15:14] == clint_msip_offset_gp[15:14]);
    assign w_is_cmp   = (w_off[15:14] == clint_mtimecmp_offset_gp[15:14]);
    assign w_is_mtime = (w_off == clint_mtime_offset_gp);

`ifdef BP_CLINT_MTIME_WRITE_EN
    assign w_mtime_ok = w_is_mtime;
`else
    assign w_mtime_ok = w_is_mtime & ~w_req.w;
`endif

    assign w_err = ~w_base_ok | ~w_align_ok
                 | ~(((w_is_msip | w_is_cmp) & w_hart_ok) | w_mtime_ok);

    assign req_ready_o = ~r_resp_v | resp_yumi_i;
    assign w_accept    = req_v_i & req_ready_o;
    assign w_wr_ok     = w_accept & w_req.w & ~w_err;
    assign w_mtime_we  = w_wr_ok & w_is_mtime;

    always_comb begin
        w_msip_we = '0;
        w_cmp_we  = '0;
        w_msip_rd = 1'b0;
        w_cmp_rd  = '0;
        for (int h = 0; h < num_harts_p; h++) begin
            if (w_hart == 11'(h)) begin
                w_msip_we[h] = w_wr_ok & w_is_msip;
                w_cmp_we[h]  = w_wr_ok & w_is_cmp;
                w_msip_rd    = r_msip[h];
                w_cmp_rd     = r_mtimecmp[h];
            end
        end
    end

    // Reads return pre-edge register values; writes and errors return zero
    always_comb begin
        w_resp.data = '0;
        w_resp.err  = w_err;
        if (!w_err && !w_req.w) begin
            if (w_is_msip) begin
                w_resp.data = {{(clint_reg_width_gp-1){1'b0}}, w_msip_rd};
            end else if (w_is_cmp) begin
                w_resp.data = w_cmp_rd;
            end else begin
                w_resp.data = w_mtime;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_resp_v <= 1'b0;
            r_resp   <= '0;
        end else if (w_accept) begin
            r_resp_v <= 1'b1;
            r_resp   <= w_resp;
        end else if (resp_yumi_i) begin
            r_resp_v <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_msip <= '0;
        end else begin
            for (int h = 0; h < num_harts_p; h++) begin
                if (w_msip_we[h]) r_msip[h] <= w_req.data[0];
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int h = 0; h < num_harts_p; h++) r_mtimecmp[h] <= '1;
            r_timer_irq <= '0;
        end else begin
            for (int h = 0; h < num_harts_p; h++) begin
                if (w_cmp_we[h]) r_mtimecmp[h] <= w_req.data;
                r_timer_irq[h] <= (w_mtime >= r_mtimecmp[h]);
            end
        end
    end

    bp_clint_mtime #(
        .mtime_div_p (mtime_div_p)
    ) u_mtime (
        .i_clk     (clk_i),
        .i_reset_n (reset_n_i),
        .i_w_v     (w_mtime_we),
        .i_w_data  (w_req.data),
        .o_mtime   (w_mtime)
    );

    assign resp_v_o    = r_resp_v;
    assign resp_data_o = r_resp.data;
    assign resp_err_o  = r_resp.err;
    assign soft_irq_o  = r_msip;
    assign timer_irq_o = r_timer_irq;

endmodule

// File: tb/tb_bp_clint_mhart.sv
// tb/tb_bp_clint_mhart.sv - self-checking bench for bp_clint_mhart (div 1 and div 3 instances)
module tb_bp_clint_mhart;

`ifdef BP_CLINT_MTIME_WRITE_EN
    localparam bit MTW = 1'b1;
`else
    localparam bit MTW = 1'b0;
`endif
    localparam int NH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_v = 1'b0;
    logic        req_w = 1'b0;
    logic [39:0] req_addr = '0;
    logic [63:0] req_data = '0;
    logic        resp_yumi = 1'b0;

    logic        ready_a, ready_b, resp_v_a, resp_v_b, err_a, err_b;
    logic [63:0] data_a, data_b;
    logic [1:0]  soft_a, soft_b, timer_a, timer_b;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [63:0] m_base_val;
    int          m_base_edge;
    logic        m_msip [NH];
    logic [63:0] m_cmp [NH];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bp_clint_mhart #(.num_harts_p(NH), .paddr_width_p(40), .mtime_div_p(1)) dut_a (
        .clk_i(clk), .reset_n_i(rst_n), .req_v_i(req_v), .req_ready_o(ready_a),
        .req_w_i(req_w), .req_addr_i(req_addr), .req_data_i(req_data),
        .resp_v_o(resp_v_a), .resp_yumi_i(resp_yumi), .resp_data_o(data_a),
        .resp_err_o(err_a), .soft_irq_o(soft_a), .timer_irq_o(timer_a));

    bp_clint_mhart #(.num_harts_p(NH), .paddr_width_p(40), .mtime_div_p(3)) dut_b (
        .clk_i(clk), .reset_n_i(rst_n), .req_v_i(req_v), .req_ready_o(ready_b),
        .req_w_i(req_w), .req_addr_i(req_addr), .req_data_i(req_data),
        .resp_v_o(resp_v_b), .resp_yumi_i(resp_yumi), .resp_data_o(data_b),
        .resp_err_o(err_b), .soft_irq_o(soft_b), .timer_irq_o(timer_b));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // mtime value present just before posedge number n
    function automatic logic [63:0] mt_at(input int n, input int div);
        return m_base_val + 64'((n - m_base_edge - 1) / div);
    endfunction

    // kind: 0 error, 1 msip, 2 mtimecmp, 3 mtime
    function automatic void decode(input logic w, input logic [39:0] a, output int kind, output int h);
        int off;
        off  = int'(a[15:0]);
        h    = 0;
        kind = 0;
        if (a[39:16] != 24'h30 || a[2:0] != 3'd0) kind = 0;
        else if (off < 'h4000) begin h = off / 8; kind = (h < NH) ? 1 : 0; end
        else if (off < 'h8000) begin h = (off - 'h4000) / 8; kind = (h < NH) ? 2 : 0; end
        else if (off == 'h8000) kind = (w && !MTW) ? 0 : 3;
        else kind = 0;
    endfunction

    task automatic model_reset();
        m_base_val  = '0;
        m_base_edge = cyc;
        for (int h = 0; h < NH; h++) begin
            m_msip[h] = 1'b0;
            m_cmp[h]  = '1;
        end
    endtask

    task automatic check_irqs();
        logic [1:0] ta, tb;
        for (int h = 0; h < NH; h++) begin
            ta[h] = (mt_at(cyc, 1) >= m_cmp[h]);
            tb[h] = (mt_at(cyc, 3) >= m_cmp[h]);
        end
        chk("timer_irq", {60'd0, timer_b, timer_a}, {60'd0, tb, ta});
        chk("soft_irq", {60'd0, soft_b, soft_a}, {60'd0, m_msip[1], m_msip[0], m_msip[1], m_msip[0]});
    endtask

    // Entered near a negedge; returns at the negedge after the response was consumed
    task automatic do_txn(input logic w, input logic [39:0] a, input logic [63:0] d,
                          output logic [63:0] ra, output logic [63:0] rb,
                          output logic ea, output logic eb,
                          output logic [63:0] xa, output logic [63:0] xb, output logic xe);
        int n, kind, h;
        req_v = 1'b1; req_w = w; req_addr = a; req_data = d; resp_yumi = 1'b0;
        n = cyc + 1;
        decode(w, a, kind, h);
        xe = (kind == 0);
        xa = '0;
        xb = '0;
        if (!w) begin
            if (kind == 1) begin xa = {63'd0, m_msip[h]}; xb = xa; end
            else if (kind == 2) begin xa = m_cmp[h]; xb = xa; end
            else if (kind == 3) begin xa = mt_at(n, 1); xb = mt_at(n, 3); end
        end
        #1;
        chk("req_ready", {63'd0, ready_a & ready_b}, 64'd1);
        @(posedge clk);
        if (w) begin
            if (kind == 1) m_msip[h] = d[0];
            else if (kind == 2) m_cmp[h] = d;
            else if (kind == 3) begin m_base_edge = n; m_base_val = d; end
        end
        @(negedge clk);
        req_v = 1'b0;
        chk("resp_v", {62'd0, resp_v_b, resp_v_a}, 64'd3);
        chk("soft_after_write", {60'd0, soft_b, soft_a}, {60'd0, m_msip[1], m_msip[0], m_msip[1], m_msip[0]});
        ra = data_a; rb = data_b; ea = err_a; eb = err_b;
        resp_yumi = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_yumi = 1'b0;
    endtask

    typedef struct {
        logic        w;
        logic [39:0] addr;
        logic [63:0] data;
        logic        exp_err;
        logic [63:0] exp_data;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] ra, rb, xa, xb, hold_data;
        logic        ea, eb, xe, w;
        logic [39:0] a;
        logic [63:0] d;
        int          sel, h, wait_k;

        vecs[0]  = '{1'b1, 40'h30_0000, 64'hFE, 1'b0, 64'd0};
        vecs[1]  = '{1'b0, 40'h30_0000, 64'd0, 1'b0, 64'd0};
        vecs[2]  = '{1'b1, 40'h30_0000, 64'h3, 1'b0, 64'd0};
        vecs[3]  = '{1'b0, 40'h30_0000, 64'd0, 1'b0, 64'd1};
        vecs[4]  = '{1'b1, 40'h30_4008, 64'h1234_5678_9ABC_DEF0, 1'b0, 64'd0};
        vecs[5]  = '{1'b0, 40'h30_4008, 64'd0, 1'b0, 64'h1234_5678_9ABC_DEF0};
        vecs[6]  = '{1'b0, 40'h30_0010, 64'd0, 1'b1, 64'd0};
        vecs[7]  = '{1'b0, 40'h30_4004, 64'd0, 1'b1, 64'd0};
        vecs[8]  = '{1'b0, 40'h31_8000, 64'd0, 1'b1, 64'd0};
        vecs[9]  = '{1'b0, 40'h30_C000, 64'd0, 1'b1, 64'd0};
        vecs[10] = '{1'b1, 40'h30_4010, 64'd5, 1'b1, 64'd0};
        vecs[11] = '{1'b0, 40'h01_0030_8000, 64'd0, 1'b1, 64'd0};
        vecs[12] = '{1'b1, 40'h30_0000, 64'd0, 1'b0, 64'd0};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_resp_v", {62'd0, resp_v_b, resp_v_a}, 64'd0);
        chk("rst_resp_data", data_a | data_b, 64'd0);
        chk("rst_resp_err", {62'd0, err_b, err_a}, 64'd0);
        chk("rst_irqs", {56'd0, soft_b, soft_a, timer_b, timer_a}, 64'd0);
        rst_n = 1'b1;
        model_reset();

        // mtime after 10 idle cycles
        repeat (10) @(negedge clk);
        do_txn(1'b0, 40'h30_8000, 64'd0, ra, rb, ea, eb, xa, xb, xe);
        chk("mtime_10", ra, 64'd10);
        chk("mtime_10_err", {63'd0, ea}, 64'd0);
        chk("mtime_div3", rb, xb);

        // msip hart 1
        do_txn(1'b1, 40'h30_0008, 64'd1, ra, rb, ea, eb, xa, xb, xe);
        chk("msip1_soft", {62'd0, soft_a}, 64'h2);
        do_txn(1'b0, 40'h30_0008, 64'd0, ra, rb, ea, eb, xa, xb, xe);
        chk("msip1_read", ra, 64'd1);
        chk("msip1_read_b", rb, 64'd1);
        check_irqs();

        // mtimecmp[0] = 0x20 written while mtime = 0x1E
        wait_k = 0;
        while (mt_at(cyc + 1, 1) != 64'h1E && wait_k < 100) begin
            @(negedge clk);
            wait_k++;
        end
        if (wait_k >= 100) begin
            errors++;
            $display("FAIL mtime_1e_wait: did not reach 1e, at %h", mt_at(cyc + 1, 1));
        end
        do_txn(1'b1, 40'h30_4000, 64'h20, ra, rb, ea, eb, xa, xb, xe);
        chk("timer_pre", {63'd0, timer_a[0]}, 64'd0);
        check_irqs();
        @(negedge clk);
        chk("timer_rise", {63'd0, timer_a[0]}, 64'd1);
        repeat (4) begin
            check_irqs();
            @(negedge clk);
        end

        // Decode table
        for (int i = 0; i < NV; i++) begin
            do_txn(vecs[i].w, vecs[i].addr, vecs[i].data, ra, rb, ea, eb, xa, xb, xe);
            chk($sformatf("vec%0d_data_a", i), ra, vecs[i].exp_data);
            chk($sformatf("vec%0d_data_b", i), rb, vecs[i].exp_data);
            chk($sformatf("vec%0d_err", i), {62'd0, eb, ea}, {62'd0, vecs[i].exp_err, vecs[i].exp_err});
            check_irqs();
        end

        // Randomized traffic against the model
        for (int it = 0; it < 150; it++) begin
            sel = $urandom_range(0, 7);
            h   = $urandom_range(0, 2);
            d   = {$urandom, $urandom};
            w   = 1'($urandom_range(0, 1));
            case (sel)
                0: begin w = 1'b1; a = 40'h30_0000 + 40'(h * 8); end
                1: begin w = 1'b0; a = 40'h30_0000 + 40'(h * 8); end
                2: begin
                    w = 1'b1;
                    a = 40'h30_4000 + 40'(h * 8);
                    if ($urandom_range(0, 3) != 0) d = mt_at(cyc + 1, 1) + 64'($urandom_range(0, 10)) - 64'd5;
                end
                3: begin w = 1'b0; a = 40'h30_4000 + 40'(h * 8); end
                4: begin w = 1'b0; a = 40'h30_8000; end
                5: begin w = ($urandom_range(0, 3) == 0); a = 40'h30_8000; end
                6: a = {24'h30 ^ 24'($urandom_range(1, 255)), 16'($urandom) & 16'hFFF8};
                default: a = 40'h30_0000 | 40'($urandom_range(0, 16'hFFFF));
            endcase
            do_txn(w, a, d, ra, rb, ea, eb, xa, xb, xe);
            chk("rnd_data_a", ra, xa);
            chk("rnd_data_b", rb, xb);
            chk("rnd_err", {62'd0, eb, ea}, {62'd0, xe, xe});
            check_irqs();
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                check_irqs();
            end
        end

        // Response slot held: no acceptance while yumi low, then back-to-back on yumi
        req_v = 1'b1; req_w = 1'b0; req_addr = 40'h30_4000; req_data = '0; resp_yumi = 1'b0;
        hold_data = m_cmp[0];
        @(posedge clk);
        @(negedge clk);
        req_addr = 40'h30_0008;
        repeat (5) begin
            #1;
            chk("hold_ready", {62'd0, ready_b, ready_a}, 64'd0);
            chk("hold_resp_v", {62'd0, resp_v_b, resp_v_a}, 64'd3);
            chk("hold_data", data_a, hold_data);
            @(negedge clk);
        end
        resp_yumi = 1'b1;
        #1;
        chk("yumi_ready", {62'd0, ready_b, ready_a}, 64'd3);
        xa = {63'd0, m_msip[1]};
        @(posedge clk);
        @(negedge clk);
        req_v = 1'b0;
        resp_yumi = 1'b0;
        chk("b2b_resp_v", {62'd0, resp_v_b, resp_v_a}, 64'd3);
        chk("b2b_data", data_a, xa);
        resp_yumi = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_yumi = 1'b0;
        check_irqs();

        // mtime write / wrap
`ifdef BP_CLINT_MTIME_WRITE_EN
        do_txn(1'b1, 40'h30_8000, '1, ra, rb, ea, eb, xa, xb, xe);
        chk("mtw_err", {62'd0, eb, ea}, 64'd0);
        check_irqs();
        do_txn(1'b0, 40'h30_8000, 64'd0, ra, rb, ea, eb, xa, xb, xe);
        chk("mtw_b_hold", rb, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("mtw_a_wrap", ra, xa);
        do_txn(1'b0, 40'h30_8000, 64'd0, ra, rb, ea, eb, xa, xb, xe);
        chk("mtw_b_wrap", rb, 64'd0);
        chk("mtw_a", ra, xa);
`else
        do_txn(1'b1, 40'h30_8000, '1, ra, rb, ea, eb, xa, xb, xe);
        chk("mtw_err", {62'd0, eb, ea}, 64'd3);
        chk("mtw_err_data", ra | rb, 64'd0);
        do_txn(1'b0, 40'h30_8000, 64'd0, ra, rb, ea, eb, xa, xb, xe);
        chk("mtw_unchanged_a", ra, xa);
        chk("mtw_unchanged_b", rb, xb);
`endif
        check_irqs();

        // Reset while a response is pending
        req_v = 1'b1; req_w = 1'b0; req_addr = 40'h30_0008; resp_yumi = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_v = 1'b0;
        chk("pend_resp_v", {62'd0, resp_v_b, resp_v_a}, 64'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_resp_v", {62'd0, resp_v_b, resp_v_a}, 64'd0);
        chk("async_rst_soft", {60'd0, soft_b, soft_a}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        #1;
        chk("post_rst_ready", {62'd0, ready_b, ready_a}, 64'd3);
        chk("post_rst_resp_v", {62'd0, resp_v_b, resp_v_a}, 64'd0);
        repeat (4) @(negedge clk);
        do_txn(1'b0, 40'h30_8000, 64'd0, ra, rb, ea, eb, xa, xb, xe);
        chk("post_rst_mtime_a", ra, xa);
        chk("post_rst_mtime_b", rb, xb);
        check_irqs();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
